// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Arbitrates the register-file write port between the pipeline
//            writeback (req0) and the mult/div unit (req1), with a
//            bounded-starvation guarantee for req1.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [4:0]            req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [4:0]            req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  wr_enable,
    output logic [4:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [31:0]           wr_select,
    output logic                  starved
);

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    logic [3:0]            r_wait_cnt;
    logic                  r_wr_enable;
    logic [4:0]            r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_starved;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_xfer;
    logic [4:0]            w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;

    assign w_starved = (r_wait_cnt == c_limit);

    // Once starved, req1 is still valid (the counter clears whenever it drops).
    assign w_grant0 = req0_valid && !w_starved;
    assign w_grant1 = req1_valid && (w_starved || !req0_valid);
    assign w_xfer   = w_grant0 || w_grant1;

    assign w_win_addr = w_grant1 ? req1_addr : req0_addr;
    assign w_win_data = w_grant1 ? req1_data : req0_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (!req1_valid || w_grant1) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt < c_limit) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Register-0 writes are accepted but never strobed into the file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_enable <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= '0;
        end else if (w_xfer) begin
            r_wr_enable <= (w_win_addr != 5'd0);
            r_wr_addr   <= w_win_addr;
            r_wr_data   <= w_win_data;
        end else begin
            r_wr_enable <= 1'b0;
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_wr_select
        assign wr_select[i] = r_wr_enable && (r_wr_addr == 5'(i));
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign wr_enable  = r_wr_enable;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign starved    = w_starved;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed scoreboard bench for regfile_wb_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DATA_WIDTH   = 32;
    localparam int STARVE_LIMIT = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  req0_valid, req1_valid;
    logic [4:0]            req0_addr, req1_addr;
    logic [DATA_WIDTH-1:0] req0_data, req1_data;
    logic                  req0_ready, req1_ready;
    logic                  wr_enable;
    logic [4:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [31:0]           wr_select;
    logic                  starved;

    regfile_wb_arbiter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_select (wr_select),
        .starved   (starved)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]            addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t q_exp[$];
    int  checks = 0;
    int  passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    task automatic push(input logic [4:0] a, input logic [DATA_WIDTH-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q_exp.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (wr_enable) begin
            if (q_exp.size() == 0) begin
                checks++;
                $display("FAIL sb_extra_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = q_exp.pop_front();
                check("sb_addr", 64'(wr_addr), 64'(e.addr));
                check("sb_data", 64'(wr_data), 64'(e.data));
                check("sb_select", 64'(wr_select), 64'(32'd1 << e.addr));
            end
        end else if (!reset) begin
            check("idle_select", 64'(wr_select), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with both requesters already valid
        reset      = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        step(); step();
        check("rst_wr_enable", 64'(wr_enable), 64'd0);
        check("rst_wr_select", 64'(wr_select), 64'd0);
        check("rst_starved",   64'(starved),   64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req0_ready", 64'(req0_ready), 64'd1);
        check("post_rst_req1_ready", 64'(req1_ready), 64'd0);
        push(5'd3, 32'h33);
        step();
        req0_valid = 1'b0;
        #1;
        check("req1_wins_alone", 64'(req1_ready), 64'd1);
        push(5'd4, 32'h44);
        step();
        req1_valid = 1'b0;

        // Simple req0 write and one-cycle strobe
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        check("w5_req0_ready", 64'(req0_ready), 64'd1);
        push(5'd5, 32'hDEADBEEF);
        step();
        req0_valid = 1'b0;
        #1;
        check("w5_strobe", 64'(wr_enable), 64'd1);
        check("w5_select", 64'(wr_select), 64'h20);
        step();
        check("w5_strobe_drops", 64'(wr_enable), 64'd0);

        // Starvation: req0 continuously valid, req1 waits STARVE_LIMIT cycles
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBB;
        for (int c = 0; c < STARVE_LIMIT; c++) begin
            #1;
            check("starve_wait_req1_ready", 64'(req1_ready), 64'd0);
            check("starve_wait_req0_ready", 64'(req0_ready), 64'd1);
            check("starve_wait_starved",    64'(starved),    64'd0);
            push(5'd10, req0_data);
            step();
            req0_data = req0_data + 32'd1;
        end
        #1;
        check("starved_flag",       64'(starved),    64'd1);
        check("starved_req1_ready", 64'(req1_ready), 64'd1);
        check("starved_req0_ready", 64'(req0_ready), 64'd0);
        push(5'd11, 32'hBB);
        step();
        req1_valid = 1'b0;
        #1;
        check("unstarved_flag",       64'(starved),    64'd0);
        check("unstarved_req0_ready", 64'(req0_ready), 64'd1);
        push(5'd10, req0_data);
        step();
        req0_valid = 1'b0;

        // Same address on both sides: req0 then req1
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h2;
        #1;
        check("same_addr_req0_first", 64'(req0_ready), 64'd1);
        push(5'd7, 32'h1);
        step();
        req0_valid = 1'b0;
        #1;
        check("same_addr_req1_second", 64'(req1_ready), 64'd1);
        push(5'd7, 32'h2);
        step();
        req1_valid = 1'b0;

        // Register-0 write is accepted and discarded
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h55;
        #1;
        check("r0_req1_ready", 64'(req1_ready), 64'd1);
        step();
        req1_valid = 1'b0;
        #1;
        check("r0_no_strobe", 64'(wr_enable), 64'd0);
        check("r0_no_select", 64'(wr_select), 64'd0);
        step();

        // Reset right after a transfer drops the pending write
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #1;
        check("drop_req0_ready", 64'(req0_ready), 64'd1);
        step();
        reset      = 1'b1;
        req0_valid = 1'b0;
        #1;
        check("drop_wr_enable", 64'(wr_enable), 64'd0);
        check("drop_wr_addr",   64'(wr_addr),   64'd0);
        check("drop_wr_data",   64'(wr_data),   64'd0);
        check("drop_wr_select", 64'(wr_select), 64'd0);
        check("drop_starved",   64'(starved),   64'd0);
        step();
        check("drop_hold_enable", 64'(wr_enable), 64'd0);
        reset = 1'b0;

        // Top register address
        req0_valid = 1'b1; req0_addr = 5'd31; req0_data = 32'hF00D;
        push(5'd31, 32'hF00D);
        step();
        req0_valid = 1'b0;
        step(); step(); step();
        check("sb_drained", 64'(q_exp.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
